axi_sram_slave: RTL and testbench
=================================

# axi_sram_slave

AXI4 slave memory model that sits directly downstream of the NPC read/write arbiter and terminates its single memory-side port. It accepts one read burst and one write burst at a time, with independent read and write engines. Bursts may be FIXED, INCR or WRAP, 32-bit beats. It inserts a configurable read latency and returns OKAY/SLVERR/DECERR responses with ID echo.

## Interface
Parameters:
- BASE, 32'h8000_0000, byte address of word 0
- DEPTH, 4096, memory size in 32-bit words (power of two)
- RD_LAT, 1, extra idle cycles between AR handshake and first R beat (0..15)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- mem_arvalid/mem_arready  in/out  1  read address handshake
- mem_araddr  in  32  read byte address
- mem_arid  in  4; mem_arlen  in  8; mem_arsize  in  3; mem_arburst  in  2  read burst attributes
- mem_rvalid/mem_rready  out/in  1  read data handshake
- mem_rdata  out  32; mem_rresp  out  2; mem_rid  out  4; mem_rlast  out  1
- mem_awvalid/mem_awready  in/out  1  write address handshake
- mem_awaddr  in  32; mem_awid  in  4; mem_awlen  in  8; mem_awsize  in  3; mem_awburst  in  2
- mem_wvalid/mem_wready  in/out  1; mem_wdata  in  32; mem_wstrb  in  4; mem_wlast  in  1
- mem_bvalid/mem_bready  out/in  1; mem_bresp  out  2; mem_bid  out  4

## Operation
- Read FSM states:
  - R_IDLE: arready=1. On AR fire, latch addr, id, len, size and burst. Go to R_WAIT if RD_LAT>0, else R_DATA.
  - R_WAIT: count RD_LAT cycles, then go to R_DATA.
  - R_DATA: rvalid=1, rid=latched id, rlast=(beat==len). On R fire, advance the address. On the last beat, return to R_IDLE.
- Read data is mem[(addr-BASE)>>2], captured into a register when entering the beat. rdata, rresp and rlast stay stable while rvalid && !rready.
- Write FSM states:
  - W_IDLE: awready=1. On AW fire, latch attributes and go to W_DATA.
  - W_DATA: wready=1. Each W fire writes the enabled bytes per wstrb and advances the address. Go to W_RESP when wlast=1 or when the beat count reaches len, whichever comes first.
  - W_RESP: bvalid=1, bid=latched id. On B fire, go to W_IDLE.
- Next-address rule:
  - FIXED (00): address unchanged.
  - INCR (01): +4.
  - WRAP (10): +4, wrapping inside a (len+1)*4-byte aligned window.
  - Reserved (11): treated as INCR.
- Response rules:
  - Address outside [BASE, BASE+4*DEPTH) -> DECERR (11). rdata=0 and the write is suppressed.
  - size>2, or WRAP with len not in {1,3,7,15} -> SLVERR (10).
  - Otherwise OKAY (00).
  - Errors are per-beat for reads. bresp is the worst of all beats in the burst.
- wlast arriving early, or missing at the len-th beat, forces bresp=SLVERR; the burst still ends at the earlier of the two events.
- Read and write engines run concurrently. When both access the same word in one cycle, the read returns the old data and the write commits.

## Timing
- Reset (async assert, sync release) puts both FSMs in IDLE.
- Output values during reset: arready=1, awready=1, rvalid=0, wready=0, bvalid=0. rdata, rresp, rid, rlast, bresp and bid are all 0. Memory contents are not cleared.
- The first R beat is asserted RD_LAT+1 cycles after the AR-fire edge. Beats are back-to-back while rready=1.
- wready is asserted the cycle after AW fire. bvalid is asserted the cycle after the final W fire.
- There is no combinational path from any valid to any ready. arready and awready depend only on FSM state.
- Reset asserted mid-burst aborts the burst with no response. Any partially written beats remain in memory.

## Structure
- Shared package axi_pkg holds:
  - response codes: RESP_OKAY, RESP_SLVERR, RESP_DECERR
  - burst codes: BURST_FIXED, BURST_INCR, BURST_WRAP
  - field width constants: ID_W=4, LEN_W=8
- One sub-module, axi_burst_addr, is combinational: (addr, len, burst) -> next_addr. It is instantiated twice, once per engine.

## Test plan
- Single read: write 0xDEADBEEF to BASE, then AR at BASE with len=0 and RD_LAT=1 -> rvalid 2 cycles after AR fire, rdata=0xDEADBEEF, rlast=1, rresp=00, rid matching arid.
- INCR read burst with len=3 from BASE+0x10 and rready toggling 1/0 -> four beats in address order. Data is held stable during stalls. rlast is asserted on beat 4 only.
- WRAP read with len=3 at BASE+0x18 -> beat addresses 0x18, 0x1C, 0x10, 0x14.
- Byte-strobe write with wdata=0x11223344 and wstrb=0101 over existing 0xAABBCCDD -> readback 0xAA22CC44, bresp=00, bid echoed.
- Out-of-range AR at 0x0000_1000 -> rresp=11, rdata=0. AW with awsize=3 -> bresp=10 and memory unchanged.
- Concurrent read and write to the same word in one cycle -> read returns the old value and a later read returns the new value. Reset asserted during R_DATA -> rvalid drops immediately and arready=1.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg
// Shared definitions for the AXI4 SRAM slave:
//   - response and burst encodings
//   - field widths (ID_W, LEN_W)
//   - read and write engine state encodings
//   - per-beat response classification and response merging helpers
package axi_pkg;

  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Classify one beat. Decode errors take priority over protocol errors.
  // span is the window size in bytes (4*DEPTH), one bit wider than an address.
  function automatic logic [1:0] beat_resp(input logic [31:0]      addr,
                                           input logic [31:0]      base,
                                           input logic [32:0]      span,
                                           input logic [2:0]       size,
                                           input logic [1:0]       burst,
                                           input logic [LEN_W-1:0] len);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    if ((addr < base) || (off >= span)) begin
      return RESP_DECERR;
    end
    if ((size > 3'd2) || ((burst == BURST_WRAP) && !wrap_len_ok(len))) begin
      return RESP_SLVERR;
    end
    return RESP_OKAY;
  endfunction

  // The numeric encoding already orders severity: OKAY < SLVERR < DECERR.
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if
// Memory-side AXI4 channel bundle between the NPC arbiter (master) and the
// SRAM slave. Carries the AR, R, AW, W and B channels; clock and reset are
// kept outside the bundle.
//   slave  modport: used by axi_sram_slave
//   master modport: used by whatever drives the memory port
interface axi_sram_slave_if;

  // read address
  logic                     mem_arvalid;
  logic                     mem_arready;
  logic [31:0]              mem_araddr;
  logic [axi_pkg::ID_W-1:0] mem_arid;
  logic [axi_pkg::LEN_W-1:0] mem_arlen;
  logic [2:0]               mem_arsize;
  logic [1:0]               mem_arburst;
  // read data
  logic                     mem_rvalid;
  logic                     mem_rready;
  logic [31:0]              mem_rdata;
  logic [1:0]               mem_rresp;
  logic [axi_pkg::ID_W-1:0] mem_rid;
  logic                     mem_rlast;
  // write address
  logic                     mem_awvalid;
  logic                     mem_awready;
  logic [31:0]              mem_awaddr;
  logic [axi_pkg::ID_W-1:0] mem_awid;
  logic [axi_pkg::LEN_W-1:0] mem_awlen;
  logic [2:0]               mem_awsize;
  logic [1:0]               mem_awburst;
  // write data
  logic                     mem_wvalid;
  logic                     mem_wready;
  logic [31:0]              mem_wdata;
  logic [3:0]               mem_wstrb;
  logic                     mem_wlast;
  // write response
  logic                     mem_bvalid;
  logic                     mem_bready;
  logic [1:0]               mem_bresp;
  logic [axi_pkg::ID_W-1:0] mem_bid;

  modport slave (
    input  mem_arvalid, mem_araddr, mem_arid, mem_arlen, mem_arsize, mem_arburst,
    output mem_arready,
    output mem_rvalid, mem_rdata, mem_rresp, mem_rid, mem_rlast,
    input  mem_rready,
    input  mem_awvalid, mem_awaddr, mem_awid, mem_awlen, mem_awsize, mem_awburst,
    output mem_awready,
    input  mem_wvalid, mem_wdata, mem_wstrb, mem_wlast,
    output mem_wready,
    output mem_bvalid, mem_bresp, mem_bid,
    input  mem_bready
  );

  modport master (
    output mem_arvalid, mem_araddr, mem_arid, mem_arlen, mem_arsize, mem_arburst,
    input  mem_arready,
    input  mem_rvalid, mem_rdata, mem_rresp, mem_rid, mem_rlast,
    output mem_rready,
    output mem_awvalid, mem_awaddr, mem_awid, mem_awlen, mem_awsize, mem_awburst,
    input  mem_awready,
    output mem_wvalid, mem_wdata, mem_wstrb, mem_wlast,
    input  mem_wready,
    input  mem_bvalid, mem_bresp, mem_bid,
    output mem_bready
  );

endinterface

// File: rtl/axi_burst_addr.sv
// axi_burst_addr
// Combinational next-beat address for 32-bit beats.
//   addr_i      current beat byte address
//   len_i       AXI burst length (beats - 1)
//   burst_i     burst type (FIXED / INCR / WRAP / reserved)
//   next_addr_o byte address of the following beat
module axi_burst_addr
  import axi_pkg::*;
(
  input  logic [31:0]      addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [1:0]       burst_i,
  output logic [31:0]      next_addr_o
);

  logic [31:0] incr_addr;
  logic [31:0] win_mask;

  assign incr_addr = addr_i + 32'd4;
  // For legal wrap lengths (len+1 a power of two) this is window_bytes - 1.
  assign win_mask  = ({24'd0, len_i} << 2) | 32'd3;

  always_comb begin
    next_addr_o = incr_addr;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP: begin
        // An illegal wrap length is already flagged SLVERR; step linearly so
        // the engine still walks a well-defined sequence.
        if (wrap_len_ok(len_i)) begin
          next_addr_o = (addr_i & ~win_mask) | (incr_addr & win_mask);
        end
      end
      default: next_addr_o = incr_addr;  // INCR and reserved
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave
// AXI4 slave SRAM model terminating the NPC arbiter memory port. Independent
// read and write engines, one burst in flight each; FIXED/INCR/WRAP bursts of
// 32-bit beats; programmable read latency; OKAY/SLVERR/DECERR with ID echo.
// Ports:
//   clock  sole clock, rising edge
//   reset  asynchronous assert, active-high; both engines return to idle
//   bus    axi_sram_slave_if.slave - AR, R, AW, W, B channels
// Parameters:
//   BASE    byte address of word 0
//   DEPTH   words of storage (power of two, >= 2)
//   RD_LAT  idle cycles between AR handshake and first R beat (0..15)
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          DEPTH  = 4096,
  parameter int          RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  axi_sram_slave_if.slave   bus
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [32:0] SPAN   = 33'(DEPTH) << 2;
  localparam logic [3:0]  LAT_M1 = 4'(RD_LAT - 1);

  // ---------------------------------------------------------------- read engine
  rd_state_e          r_state_q, r_state_d;
  logic [31:0]        raddr_q;
  logic [LEN_W-1:0]   rlen_q;
  logic [LEN_W-1:0]   rbeat_q;
  logic [2:0]         rsize_q;
  logic [1:0]         rburst_q;
  logic [ID_W-1:0]    rid_q;
  logic [3:0]         rwait_q;
  logic [1:0]         rresp_q;

  logic               ar_fire;
  logic               r_fire;
  logic               r_is_last;
  logic [31:0]        r_next_addr;

  // Address/attributes of the beat being loaded into the read data register.
  logic               rd_cap_en;
  logic [31:0]        cap_addr;
  logic [2:0]         cap_size;
  logic [LEN_W-1:0]   cap_len;
  logic [1:0]         cap_burst;
  logic [1:0]         cap_resp;
  logic [AW-1:0]      rd_idx;
  logic [31:0]        rd_word;

  assign ar_fire   = (r_state_q == R_IDLE) && bus.mem_arvalid;
  assign r_fire    = (r_state_q == R_DATA) && bus.mem_rready;
  assign r_is_last = (rbeat_q == rlen_q);

  axi_burst_addr u_rd_addr (
    .addr_i      (raddr_q),
    .len_i       (rlen_q),
    .burst_i     (rburst_q),
    .next_addr_o (r_next_addr)
  );

  always_comb begin
    r_state_d = r_state_q;
    rd_cap_en = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (bus.mem_arvalid) begin
          if (RD_LAT == 0) begin
            r_state_d = R_DATA;
            rd_cap_en = 1'b1;
          end else begin
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (rwait_q == 4'd0) begin
          r_state_d = R_DATA;
          rd_cap_en = 1'b1;
        end
      end
      R_DATA: begin
        if (bus.mem_rready) begin
          if (r_is_last) begin
            r_state_d = R_IDLE;
          end else begin
            rd_cap_en = 1'b1;  // fetch the following beat on this handshake
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // In idle the beat comes straight off the AR channel; after a handshake it
  // is the next burst address; coming out of the latency wait it is the
  // latched start address.
  always_comb begin
    cap_addr  = raddr_q;
    cap_size  = rsize_q;
    cap_len   = rlen_q;
    cap_burst = rburst_q;
    if (r_state_q == R_IDLE) begin
      cap_addr  = bus.mem_araddr;
      cap_size  = bus.mem_arsize;
      cap_len   = bus.mem_arlen;
      cap_burst = bus.mem_arburst;
    end else if (r_state_q == R_DATA) begin
      cap_addr  = r_next_addr;
    end
  end

  assign cap_resp = beat_resp(cap_addr, BASE, SPAN, cap_size, cap_burst, cap_len);
  assign rd_idx   = AW'((cap_addr - BASE) >> 2);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rid_q     <= '0;
      rwait_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_fire) begin
        raddr_q  <= bus.mem_araddr;
        rlen_q   <= bus.mem_arlen;
        rsize_q  <= bus.mem_arsize;
        rburst_q <= bus.mem_arburst;
        rid_q    <= bus.mem_arid;
        rbeat_q  <= '0;
        rwait_q  <= LAT_M1;
      end
      if ((r_state_q == R_WAIT) && (rwait_q != 4'd0)) begin
        rwait_q <= rwait_q - 4'd1;
      end
      if (rd_cap_en) begin
        rresp_q <= cap_resp;
      end
      if (r_fire) begin
        raddr_q <= r_next_addr;
        rbeat_q <= rbeat_q + 8'd1;
      end
    end
  end

  assign bus.mem_arready = (r_state_q == R_IDLE);
  assign bus.mem_rvalid  = (r_state_q == R_DATA);
  assign bus.mem_rid     = rid_q;
  assign bus.mem_rresp   = rresp_q;
  assign bus.mem_rlast   = (r_state_q == R_DATA) && r_is_last;
  // Error beats never expose array contents.
  assign bus.mem_rdata   = ((r_state_q == R_DATA) && (rresp_q == RESP_OKAY)) ? rd_word : '0;

  // --------------------------------------------------------------- write engine
  wr_state_e          w_state_q, w_state_d;
  logic [31:0]        waddr_q;
  logic [LEN_W-1:0]   wlen_q;
  logic [LEN_W-1:0]   wbeat_q;
  logic [2:0]         wsize_q;
  logic [1:0]         wburst_q;
  logic [ID_W-1:0]    wid_q;
  logic [1:0]         wresp_acc_q;

  logic               aw_fire;
  logic               w_fire;
  logic               w_is_last;
  logic               w_end;
  logic [1:0]         w_beat_resp;
  logic [1:0]         w_len_resp;
  logic [31:0]        w_next_addr;
  logic               wr_en;
  logic [AW-1:0]      wr_idx;

  assign aw_fire     = (w_state_q == W_IDLE) && bus.mem_awvalid;
  assign w_fire      = (w_state_q == W_DATA) && bus.mem_wvalid;
  assign w_is_last   = (wbeat_q == wlen_q);
  // The burst closes on whichever comes first: wlast or the len-th beat.
  assign w_end       = bus.mem_wlast || w_is_last;
  assign w_beat_resp = beat_resp(waddr_q, BASE, SPAN, wsize_q, wburst_q, wlen_q);
  assign w_len_resp  = (bus.mem_wlast != w_is_last) ? RESP_SLVERR : RESP_OKAY;
  assign wr_en       = w_fire && (w_beat_resp == RESP_OKAY);
  assign wr_idx      = AW'((waddr_q - BASE) >> 2);

  axi_burst_addr u_wr_addr (
    .addr_i      (waddr_q),
    .len_i       (wlen_q),
    .burst_i     (wburst_q),
    .next_addr_o (w_next_addr)
  );

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: if (bus.mem_awvalid)           w_state_d = W_DATA;
      W_DATA: if (bus.mem_wvalid && w_end)   w_state_d = W_RESP;
      W_RESP: if (bus.mem_bready)            w_state_d = W_IDLE;
      default:                               w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state_q   <= W_IDLE;
      waddr_q     <= '0;
      wlen_q      <= '0;
      wbeat_q     <= '0;
      wsize_q     <= '0;
      wburst_q    <= '0;
      wid_q       <= '0;
      wresp_acc_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_fire) begin
        waddr_q     <= bus.mem_awaddr;
        wlen_q      <= bus.mem_awlen;
        wsize_q     <= bus.mem_awsize;
        wburst_q    <= bus.mem_awburst;
        wid_q       <= bus.mem_awid;
        wbeat_q     <= '0;
        wresp_acc_q <= RESP_OKAY;
      end
      if (w_fire) begin
        waddr_q     <= w_next_addr;
        wbeat_q     <= wbeat_q + 8'd1;
        wresp_acc_q <= worst_resp(wresp_acc_q, worst_resp(w_beat_resp, w_len_resp));
      end
    end
  end

  assign bus.mem_awready = (w_state_q == W_IDLE);
  assign bus.mem_wready  = (w_state_q == W_DATA);
  assign bus.mem_bvalid  = (w_state_q == W_RESP);
  assign bus.mem_bresp   = wresp_acc_q;
  assign bus.mem_bid     = wid_q;

  // ---------------------------------------------------------------- storage
  // One byte-wide array per lane so byte strobes map onto independent write
  // enables. Read and write sit in the same clocked process, so a read of a
  // word being written in the same cycle returns the pre-write contents.
  // No reset: contents survive reset.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] ram [DEPTH];
      logic [7:0] rd_byte_q;

      always_ff @(posedge clock) begin
        if (wr_en && bus.mem_wstrb[gi]) begin
          ram[wr_idx] <= bus.mem_wdata[gi*8 +: 8];
        end
        if (rd_cap_en) begin
          rd_byte_q <= ram[rd_idx];
        end
      end

      assign rd_word[gi*8 +: 8] = rd_byte_q;
    end
  endgenerate

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave
// Directed scoreboard bench: each test pushes its expected R beats / B
// response into queues before driving the channels; a monitor process pops
// and compares whenever the slave presents rvalid or bvalid.
module tb_axi_sram_slave;
  import axi_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic [3:0]  id;
    logic        last;
  } rexp_t;

  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_sram_slave_if bus();

  axi_sram_slave #(.BASE(BASE), .DEPTH(4096), .RD_LAT(1)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  rexp_t rq[$];
  bexp_t bq[$];
  logic  rr_toggle = 1'b0;
  int    r_beat_no = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic push_r(input logic [31:0] d, input logic [1:0] r, input logic [3:0] id, input logic l);
    rexp_t e;
    e.data = d; e.resp = r; e.id = id; e.last = l;
    rq.push_back(e);
  endtask

  task automatic push_b(input logic [1:0] r, input logic [3:0] id);
    bexp_t e;
    e.resp = r; e.id = id;
    bq.push_back(e);
  endtask

  // Inputs change only at posedge+1; the monitor samples on the negedge, so a
  // valid&&ready seen there is exactly the handshake of the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_rvalid) begin
          if (rq.size() == 0) begin
            chk("r_unexpected", 64'(bus.mem_rvalid), 64'd0);
          end else begin
            chk("r_beat", {25'd0, bus.mem_rdata, bus.mem_rresp, bus.mem_rid, bus.mem_rlast},
                {25'd0, rq[0].data, rq[0].resp, rq[0].id, rq[0].last});
            if (bus.mem_rready) begin
              $display("R  beat %0d id=%0d data=%h resp=%0d last=%0d", r_beat_no,
                       bus.mem_rid, bus.mem_rdata, bus.mem_rresp, bus.mem_rlast);
              r_beat_no++;
              void'(rq.pop_front());
            end
          end
        end
        if (bus.mem_bvalid && bus.mem_bready) begin
          if (bq.size() == 0) begin
            chk("b_unexpected", 64'(bus.mem_bvalid), 64'd0);
          end else begin
            chk("b_resp", {58'd0, bus.mem_bresp, bus.mem_bid}, {58'd0, bq[0].resp, bq[0].id});
            $display("B  id=%0d resp=%0d", bus.mem_bid, bus.mem_bresp);
            void'(bq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_toggle) bus.mem_rready = ~bus.mem_rready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [1:0] burst);
    int n;
    bus.mem_araddr = a; bus.mem_arid = id; bus.mem_arlen = len;
    bus.mem_arsize = 3'd2; bus.mem_arburst = burst; bus.mem_arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.mem_arready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("ar_timeout", 64'(n), 64'd0);
    tick();
    bus.mem_arvalid = 1'b0;
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n;
    bus.mem_awaddr = a; bus.mem_awid = id; bus.mem_awlen = len;
    bus.mem_awsize = size; bus.mem_awburst = burst; bus.mem_awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.mem_awready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("aw_timeout", 64'(n), 64'd0);
    tick();
    bus.mem_awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] strb, input logic last);
    int n;
    bus.mem_wdata = d; bus.mem_wstrb = strb; bus.mem_wlast = last; bus.mem_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.mem_wready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("w_timeout", 64'(n), 64'd0);
    tick();
    bus.mem_wvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 300) begin tick(); n++; end
    if (n >= 300) chk("drain_timeout", 64'(rq.size() + bq.size()), 64'd0);
  endtask

  task automatic wr1(input logic [31:0] a, input logic [3:0] id, input logic [31:0] d, input logic [3:0] strb);
    push_b(RESP_OKAY, id);
    do_aw(a, id, 8'd0, 3'd2, BURST_INCR);
    do_w(d, strb, 1'b1);
    wait_idle();
  endtask

  initial begin
    int lat;
    int n;
    bus.mem_arvalid = 0; bus.mem_araddr = 0; bus.mem_arid = 0; bus.mem_arlen = 0;
    bus.mem_arsize = 0; bus.mem_arburst = 0; bus.mem_rready = 1;
    bus.mem_awvalid = 0; bus.mem_awaddr = 0; bus.mem_awid = 0; bus.mem_awlen = 0;
    bus.mem_awsize = 0; bus.mem_awburst = 0;
    bus.mem_wvalid = 0; bus.mem_wdata = 0; bus.mem_wstrb = 0; bus.mem_wlast = 0;
    bus.mem_bready = 1;

    // Outputs held in reset
    repeat (3) @(negedge clk);
    chk("rst_arready", 64'(bus.mem_arready), 64'd1);
    chk("rst_awready", 64'(bus.mem_awready), 64'd1);
    chk("rst_rvalid",  64'(bus.mem_rvalid),  64'd0);
    chk("rst_wready",  64'(bus.mem_wready),  64'd0);
    chk("rst_bvalid",  64'(bus.mem_bvalid),  64'd0);
    chk("rst_rdata",   64'(bus.mem_rdata),   64'd0);
    chk("rst_rresp",   64'(bus.mem_rresp),   64'd0);
    chk("rst_rid",     64'(bus.mem_rid),     64'd0);
    chk("rst_rlast",   64'(bus.mem_rlast),   64'd0);
    chk("rst_bresp",   64'(bus.mem_bresp),   64'd0);
    chk("rst_bid",     64'(bus.mem_bid),     64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single write then single read; first beat visible RD_LAT+1 = 2 edges after AR fire
    wr1(BASE, 4'd3, 32'hDEAD_BEEF, 4'hF);
    push_r(32'hDEAD_BEEF, RESP_OKAY, 4'd5, 1'b1);
    do_ar(BASE, 4'd5, 8'd0, BURST_INCR);
    lat = 1;
    @(negedge clk);
    while (!bus.mem_rvalid && lat < 50) begin @(negedge clk); lat++; end
    chk("rd_latency", 64'(lat), 64'd2);
    tick();
    wait_idle();

    // Four-beat INCR write at BASE+0x10, then INCR read back with rready toggling
    push_b(RESP_OKAY, 4'd1);
    do_aw(BASE + 32'h10, 4'd1, 8'd3, 3'd2, BURST_INCR);
    do_w(32'h1000_0001, 4'hF, 1'b0);
    do_w(32'h1000_0002, 4'hF, 1'b0);
    do_w(32'h1000_0003, 4'hF, 1'b0);
    do_w(32'h1000_0004, 4'hF, 1'b1);
    wait_idle();
    push_r(32'h1000_0001, RESP_OKAY, 4'd2, 1'b0);
    push_r(32'h1000_0002, RESP_OKAY, 4'd2, 1'b0);
    push_r(32'h1000_0003, RESP_OKAY, 4'd2, 1'b0);
    push_r(32'h1000_0004, RESP_OKAY, 4'd2, 1'b1);
    rr_toggle = 1'b1;
    do_ar(BASE + 32'h10, 4'd2, 8'd3, BURST_INCR);
    wait_idle();
    rr_toggle = 1'b0;
    bus.mem_rready = 1'b1;
    tick();

    // WRAP len=3 at +0x18: beats 0x18, 0x1C, 0x10, 0x14
    push_r(32'h1000_0003, RESP_OKAY, 4'd4, 1'b0);
    push_r(32'h1000_0004, RESP_OKAY, 4'd4, 1'b0);
    push_r(32'h1000_0001, RESP_OKAY, 4'd4, 1'b0);
    push_r(32'h1000_0002, RESP_OKAY, 4'd4, 1'b1);
    do_ar(BASE + 32'h18, 4'd4, 8'd3, BURST_WRAP);
    wait_idle();

    // Byte strobes 0101 over AABBCCDD -> AA22CC44
    wr1(BASE + 32'h40, 4'd6, 32'hAABB_CCDD, 4'hF);
    wr1(BASE + 32'h40, 4'd11, 32'h1122_3344, 4'b0101);
    push_r(32'hAA22_CC44, RESP_OKAY, 4'd6, 1'b1);
    do_ar(BASE + 32'h40, 4'd6, 8'd0, BURST_INCR);
    wait_idle();

    // Out-of-range read -> DECERR, data 0
    push_r(32'h0, RESP_DECERR, 4'd7, 1'b1);
    do_ar(32'h0000_1000, 4'd7, 8'd0, BURST_INCR);
    wait_idle();

    // awsize=3 -> SLVERR and no write
    push_b(RESP_SLVERR, 4'd8);
    do_aw(BASE + 32'h40, 4'd8, 8'd0, 3'd3, BURST_INCR);
    do_w(32'hFFFF_FFFF, 4'hF, 1'b1);
    wait_idle();
    push_r(32'hAA22_CC44, RESP_OKAY, 4'd8, 1'b1);
    do_ar(BASE + 32'h40, 4'd8, 8'd0, BURST_INCR);
    wait_idle();

    // Out-of-range write -> DECERR
    push_b(RESP_DECERR, 4'd12);
    do_aw(32'h0000_1000, 4'd12, 8'd0, 3'd2, BURST_INCR);
    do_w(32'h0BAD_0BAD, 4'hF, 1'b1);
    wait_idle();

    // Early wlast on a len=3 burst: one beat, SLVERR, beat still stored
    push_b(RESP_SLVERR, 4'd9);
    do_aw(BASE + 32'h80, 4'd9, 8'd3, 3'd2, BURST_INCR);
    do_w(32'h1234_5678, 4'hF, 1'b1);
    wait_idle();
    chk("early_wlast_awready", 64'(bus.mem_awready), 64'd1);
    push_r(32'h1234_5678, RESP_OKAY, 4'd9, 1'b1);
    do_ar(BASE + 32'h80, 4'd9, 8'd0, BURST_INCR);
    wait_idle();

    // Missing wlast at the len-th beat -> SLVERR
    push_b(RESP_SLVERR, 4'd10);
    do_aw(BASE + 32'h84, 4'd10, 8'd0, 3'd2, BURST_INCR);
    do_w(32'h0000_0084, 4'hF, 1'b0);
    wait_idle();

    // Read capture and write commit to the same word on the same edge
    wr1(BASE + 32'h50, 4'd1, 32'h5555_5555, 4'hF);
    push_b(RESP_OKAY, 4'd13);
    do_aw(BASE + 32'h50, 4'd13, 8'd0, 3'd2, BURST_INCR);
    push_r(32'h5555_5555, RESP_OKAY, 4'd2, 1'b1);
    bus.mem_araddr = BASE + 32'h50; bus.mem_arid = 4'd2; bus.mem_arlen = 8'd0;
    bus.mem_arsize = 3'd2; bus.mem_arburst = BURST_INCR; bus.mem_arvalid = 1'b1;
    tick();                                   // AR fires here
    bus.mem_arvalid = 1'b0;
    bus.mem_wdata = 32'h6666_6666; bus.mem_wstrb = 4'hF; bus.mem_wlast = 1'b1;
    bus.mem_wvalid = 1'b1;
    tick();                                   // W fire coincides with read capture
    bus.mem_wvalid = 1'b0;
    wait_idle();
    push_r(32'h6666_6666, RESP_OKAY, 4'd3, 1'b1);
    do_ar(BASE + 32'h50, 4'd3, 8'd0, BURST_INCR);
    wait_idle();

    // Reset while R_DATA is stalled: rvalid drops at once, arready returns
    bus.mem_rready = 1'b0;
    push_r(32'hDEAD_BEEF, RESP_OKAY, 4'd1, 1'b0);
    do_ar(BASE, 4'd1, 8'd3, BURST_INCR);
    n = 0;
    while (!bus.mem_rvalid && n < 50) begin tick(); n++; end
    chk("pre_rst_rvalid", 64'(bus.mem_rvalid), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_rvalid",  64'(bus.mem_rvalid),  64'd0);
    chk("midrst_arready", 64'(bus.mem_arready), 64'd1);
    rq.delete();
    tick();
    rst = 1'b0;
    bus.mem_rready = 1'b1;
    tick();

    // Memory survives reset
    push_r(32'hDEAD_BEEF, RESP_OKAY, 4'd14, 1'b1);
    do_ar(BASE, 4'd14, 8'd0, BURST_INCR);
    wait_idle();
    repeat (2) tick();
    chk("left_r", 64'(rq.size()), 64'd0);
    chk("left_b", 64'(bq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
